// File: rtl/stream_range_stats_if.sv
// Sample stream and result bus for stream_range_stats.
// The source drives data_in/valid/go/finish; the tracker drives the latched results
// and the state flags.
// The optional sum result is present only when STREAM_RANGE_STATS_SUM_EN is defined.
//
// Handshake: this bus has no ready. A sample is consumed on every rising clock edge
// where valid=1 and the tracker is collecting, or is entering collection on that edge.
// go acts on its rising edge. finish acts on its level.
// done is a one-cycle pulse that marks a fresh set of results.
interface stream_range_stats_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     data_in;
    logic                 valid;
    logic                 go;
    logic                 finish;
    logic [WIDTH-1:0]     range;
    logic [WIDTH-1:0]     min_out;
    logic [WIDTH-1:0]     max_out;
    logic [CNT_WIDTH-1:0] count;
    logic                 sat;
    logic                 done;
    logic                 busy;
    logic                 error;
`ifdef STREAM_RANGE_STATS_SUM_EN
    logic [WIDTH+CNT_WIDTH-1:0] sum;

    modport master (
        output data_in, valid, go, finish,
        input  range, min_out, max_out, count, sat, done, busy, error, sum
    );
    modport slave (
        input  data_in, valid, go, finish,
        output range, min_out, max_out, count, sat, done, busy, error, sum
    );
`else
    modport master (
        output data_in, valid, go, finish,
        input  range, min_out, max_out, count, sat, done, busy, error
    );
    modport slave (
        input  data_in, valid, go, finish,
        output range, min_out, max_out, count, sat, done, busy, error
    );
`endif
endinterface

// File: rtl/stream_range_stats.sv
// Streaming min/max/range/count tracker.
// A session opens on a go rising edge and closes on a finish level. Results latch
// at the close and are held until the next successful session.
// Signed or unsigned compare is selected by the SIGNED parameter.
// Optional feature: define STREAM_RANGE_STATS_SUM_EN to add a session sum output.
// dbg_state exposes the FSM state: 0 = IDLE, 1 = COLLECT, 2 = ERROR.
module stream_range_stats #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8,
    parameter int SIGNED    = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    stream_range_stats_if.slave        bus,
    output logic [1:0]                 dbg_state
);

    localparam int SUM_WIDTH = WIDTH + CNT_WIDTH;

    // Working min starts at the largest value of the type, and working max at the
    // smallest, so the first sample always replaces both of them.
    localparam logic [WIDTH-1:0] TYPE_MAX = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                          : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TYPE_MIN = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                          : {WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_ERROR   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 go_prev_q, go_prev_d;

    // Working registers for the session in progress.
    logic [WIDTH-1:0]     wmin_q, wmin_d;
    logic [WIDTH-1:0]     wmax_q, wmax_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                 wsat_q, wsat_d;

    // Latched results.
    logic [WIDTH-1:0]     min_out_q, min_out_d;
    logic [WIDTH-1:0]     max_out_q, max_out_d;
    logic [WIDTH-1:0]     range_q, range_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

`ifdef STREAM_RANGE_STATS_SUM_EN
    logic [SUM_WIDTH-1:0] wsum_q, wsum_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [SUM_WIDTH-1:0] base_sum, upd_sum;
    logic                 ext_bit;
`endif

    logic                 go_edge;
    logic [WIDTH-1:0]     base_min, base_max, upd_min, upd_max;
    logic [CNT_WIDTH-1:0] base_cnt, upd_cnt;
    logic                 base_sat, upd_sat;

    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    assign go_edge = bus.go & ~go_prev_q;

    // Working values after this cycle's sample, starting from a fresh session when not collecting.
    always_comb begin
        base_min = wmin_q;
        base_max = wmax_q;
        base_cnt = wcnt_q;
        base_sat = wsat_q;
`ifdef STREAM_RANGE_STATS_SUM_EN
        base_sum = wsum_q;
        ext_bit  = (SIGNED != 0) ? bus.data_in[WIDTH-1] : 1'b0;
`endif
        if (state_q != S_COLLECT) begin
            base_min = TYPE_MAX;
            base_max = TYPE_MIN;
            base_cnt = '0;
            base_sat = 1'b0;
`ifdef STREAM_RANGE_STATS_SUM_EN
            base_sum = '0;
`endif
        end

        upd_min = base_min;
        upd_max = base_max;
        upd_cnt = base_cnt;
        upd_sat = base_sat;
`ifdef STREAM_RANGE_STATS_SUM_EN
        upd_sum = base_sum;
`endif
        if (bus.valid) begin
            if (less_than(bus.data_in, base_min)) begin
                upd_min = bus.data_in;
            end
            if (less_than(base_max, bus.data_in)) begin
                upd_max = bus.data_in;
            end
            // Once the counter is pinned, later samples still move min/max but are not counted or summed.
            if (base_cnt != CNT_MAX) begin
                upd_cnt = base_cnt + CNT_WIDTH'(1);
`ifdef STREAM_RANGE_STATS_SUM_EN
                upd_sum = base_sum + {{CNT_WIDTH{ext_bit}}, bus.data_in};
`endif
                if (upd_cnt == CNT_MAX) begin
                    upd_sat = 1'b1;
                end
            end else begin
                upd_sat = 1'b1;
            end
        end
    end

    // Session FSM: next state, working register loads and result latching.
    always_comb begin
        state_d   = state_q;
        go_prev_d = bus.go;
        wmin_d    = wmin_q;
        wmax_d    = wmax_q;
        wcnt_d    = wcnt_q;
        wsat_d    = wsat_q;
        min_out_d = min_out_q;
        max_out_d = max_out_q;
        range_d   = range_q;
        count_d   = count_q;
        sat_d     = sat_q;
        done_d    = 1'b0;
`ifdef STREAM_RANGE_STATS_SUM_EN
        wsum_d    = wsum_q;
        sum_d     = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                // finish outranks a simultaneous go edge here.
                if (bus.finish) begin
                    state_d = S_ERROR;
                end else if (go_edge) begin
                    state_d = S_COLLECT;
                end
            end
            S_ERROR: begin
                if (go_edge && !bus.finish) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A go edge aborts the session, even with finish set in the same cycle.
                if (go_edge) begin
                    state_d = S_ERROR;
                end else if (bus.finish) begin
                    if (upd_cnt != '0) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        min_out_d = upd_min;
                        max_out_d = upd_max;
                        range_d   = upd_max - upd_min;
                        count_d   = upd_cnt;
                        sat_d     = upd_sat;
`ifdef STREAM_RANGE_STATS_SUM_EN
                        sum_d     = upd_sum;
`endif
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The working registers follow every cycle that enters or stays in COLLECT.
        if (state_d == S_COLLECT) begin
            wmin_d = upd_min;
            wmax_d = upd_max;
            wcnt_d = upd_cnt;
            wsat_d = upd_sat;
`ifdef STREAM_RANGE_STATS_SUM_EN
            wsum_d = upd_sum;
`endif
        end

        busy_d  = (state_d == S_COLLECT);
        error_d = (state_d == S_ERROR);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            go_prev_q <= 1'b0;
            wmin_q    <= '0;
            wmax_q    <= '0;
            wcnt_q    <= '0;
            wsat_q    <= 1'b0;
            min_out_q <= '0;
            max_out_q <= '0;
            range_q   <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef STREAM_RANGE_STATS_SUM_EN
            wsum_q    <= '0;
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            go_prev_q <= go_prev_d;
            wmin_q    <= wmin_d;
            wmax_q    <= wmax_d;
            wcnt_q    <= wcnt_d;
            wsat_q    <= wsat_d;
            min_out_q <= min_out_d;
            max_out_q <= max_out_d;
            range_q   <= range_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
`ifdef STREAM_RANGE_STATS_SUM_EN
            wsum_q    <= wsum_d;
            sum_q     <= sum_d;
`endif
        end
    end

    assign bus.min_out = min_out_q;
    assign bus.max_out = max_out_q;
    assign bus.range   = range_q;
    assign bus.count   = count_q;
    assign bus.sat     = sat_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.error   = error_q;
`ifdef STREAM_RANGE_STATS_SUM_EN
    assign bus.sum     = sum_q;
`endif
    assign dbg_state   = state_q;

endmodule
